// File: rtl/gppcu_pipe_sequencer.sv
// GPPCU pipe sequencer: fetches kernel instructions from a sync-read IMEM and steps the broadcast
// FCH/DEC/EXEC/WB pipeline, interlocking on RAW hazards and FPU busy and draining on HALT.
module gppcu_pipe_sequencer #(
    parameter int               ABW      = 11,
    parameter int               DBW      = 32,
    parameter int               CW_BITS  = 16,
    parameter int               CW_REGWR = 1,
    parameter int               OPC_LSB  = 26,
    parameter int               OPC_W    = 6,
    parameter logic [OPC_W-1:0] HALT_OPC = 6'h3F,
    parameter int               REG_W    = 5,
    parameter int               REGD_LSB = 21,
    parameter int               REGA_LSB = 16,
    parameter int               REGB_LSB = 11
) (
    input  logic               iACLK,
    input  logic               iRST,
    input  logic               iSTART,
    input  logic [ABW-1:0]     iSTART_PC,
    output logic               oRUNNING,
    output logic               oDONE,
    output logic [ABW-1:0]     oIMEM_ADDR,
    input  logic [DBW-1:0]     iIMEM_RDATA,
    output logic [DBW-1:0]     oDEC_INSTR,
    input  logic [CW_BITS-1:0] iDEC_CW,
    input  logic               iBUSY,
    output logic [DBW-1:0]     oINSTR_FCH,
    output logic [DBW-1:0]     oINSTR_DEC,
    output logic [DBW-1:0]     oINSTR_EXEC,
    output logic [DBW-1:0]     oINSTR_WB,
    output logic [CW_BITS-1:0] oCW_DEC,
    output logic [CW_BITS-1:0] oCW_EXEC,
    output logic [CW_BITS-1:0] oCW_WB
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [ABW-1:0] PC_INC = {{(ABW-1){1'b0}}, 1'b1};

    state_t               state_r;
    state_t               state_s;
    logic [ABW-1:0]       pc_r;
    logic                 fch_valid_r;
    logic                 dec_valid_r;
    logic [DBW-1:0]       instr_dec_r;
    logic [DBW-1:0]       instr_exec_r;
    logic [DBW-1:0]       instr_wb_r;
    logic [CW_BITS-1:0]   cw_exec_r;
    logic [CW_BITS-1:0]   cw_wb_r;
    logic [CW_BITS-1:0]   cw_dec_s;
    logic                 active_s;
    logic                 busy_s;
    logic                 raw_s;
    logic                 haz_s;
    logic                 shift_s;
    logic                 halt_s;
    logic                 fch_adv_s;
    logic                 exec_vld_nx_s;
    logic                 wb_vld_nx_s;

    // Both source operands are always compared against the producer's destination (conservative).
    function automatic logic raw_hit(input logic [DBW-1:0] src, input logic [DBW-1:0] dst,
                                     input logic [CW_BITS-1:0] cw);
        logic [REG_W-1:0] rd;
        rd = dst[REGD_LSB +: REG_W];
        return cw[0] & cw[CW_REGWR] &
               ((src[REGA_LSB +: REG_W] == rd) | (src[REGB_LSB +: REG_W] == rd));
    endfunction

    // Stall classification and the stage valids that the next edge will produce.
    always_comb begin
        cw_dec_s    = iDEC_CW;
        cw_dec_s[0] = dec_valid_r;
        active_s    = (state_r == ST_RUN) || (state_r == ST_DRAIN);
        busy_s      = active_s & iBUSY & cw_exec_r[0];
        raw_s       = dec_valid_r & (raw_hit(instr_dec_r, instr_exec_r, cw_exec_r) |
                                     raw_hit(instr_dec_r, instr_wb_r, cw_wb_r));
        haz_s       = active_s & ~busy_s & raw_s;
        shift_s     = active_s & ~busy_s & ~haz_s;
        halt_s      = shift_s & (state_r == ST_RUN) & dec_valid_r &
                      (instr_dec_r[OPC_LSB +: OPC_W] == HALT_OPC);
        fch_adv_s   = shift_s & ~halt_s & fch_valid_r;
        if (busy_s) begin
            exec_vld_nx_s = cw_exec_r[0];
            wb_vld_nx_s   = 1'b0;
        end else if (haz_s) begin
            exec_vld_nx_s = 1'b0;
            wb_vld_nx_s   = cw_exec_r[0];
        end else if (shift_s) begin
            exec_vld_nx_s = dec_valid_r & ~halt_s;
            wb_vld_nx_s   = cw_exec_r[0];
        end else begin
            exec_vld_nx_s = cw_exec_r[0];
            wb_vld_nx_s   = cw_wb_r[0];
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (iSTART) state_s = ST_FILL;
                else        state_s = ST_IDLE;
            end
            ST_FILL: state_s = ST_RUN;
            ST_RUN: begin
                if (halt_s) state_s = ST_DRAIN;
                else        state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (!exec_vld_nx_s && !wb_vld_nx_s) state_s = ST_DONE;
                else                                state_s = ST_DRAIN;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge iACLK) begin
        if (iRST) state_r <= ST_IDLE;
        else      state_r <= state_s;
    end

    // Pipeline registers: a stage fed by an invalid stage goes invalid but keeps its last instruction.
    always_ff @(posedge iACLK) begin
        if (iRST) begin
            pc_r         <= {ABW{1'b0}};
            fch_valid_r  <= 1'b0;
            dec_valid_r  <= 1'b0;
            instr_dec_r  <= {DBW{1'b0}};
            instr_exec_r <= {DBW{1'b0}};
            instr_wb_r   <= {DBW{1'b0}};
            cw_exec_r    <= {CW_BITS{1'b0}};
            cw_wb_r      <= {CW_BITS{1'b0}};
        end else begin
            if (state_r == ST_IDLE && iSTART) pc_r <= iSTART_PC;
            else if (fch_adv_s)              pc_r <= pc_r + PC_INC;

            if (state_r == ST_FILL) fch_valid_r <= 1'b1;
            else if (halt_s)        fch_valid_r <= 1'b0;

            if (halt_s) begin
                dec_valid_r <= 1'b0;
            end else if (shift_s) begin
                dec_valid_r <= fch_valid_r;
                if (fch_valid_r) instr_dec_r <= iIMEM_RDATA;
            end

            if (haz_s || halt_s) begin
                cw_exec_r[0] <= 1'b0;
            end else if (shift_s) begin
                if (dec_valid_r) begin
                    instr_exec_r <= instr_dec_r;
                    cw_exec_r    <= cw_dec_s;
                end else begin
                    cw_exec_r[0] <= 1'b0;
                end
            end

            if (busy_s) begin
                cw_wb_r[0] <= 1'b0;
            end else if (haz_s || shift_s) begin
                if (cw_exec_r[0]) begin
                    instr_wb_r <= instr_exec_r;
                    cw_wb_r    <= cw_exec_r;
                end else begin
                    cw_wb_r[0] <= 1'b0;
                end
            end
        end
    end

    // IMEM is sync-read: holding the address while FCH stalls keeps its data on iIMEM_RDATA.
    assign oIMEM_ADDR  = fch_adv_s ? (pc_r + PC_INC) : pc_r;
    assign oRUNNING    = (state_r != ST_IDLE);
    assign oDONE       = (state_r == ST_DONE);
    assign oDEC_INSTR  = instr_dec_r;
    assign oINSTR_FCH  = iIMEM_RDATA;
    assign oINSTR_DEC  = instr_dec_r;
    assign oINSTR_EXEC = instr_exec_r;
    assign oINSTR_WB   = instr_wb_r;
    assign oCW_DEC     = cw_dec_s;
    assign oCW_EXEC    = cw_exec_r;
    assign oCW_WB      = cw_wb_r;

endmodule

// File: tb/tb_gppcu_pipe_sequencer.sv
// Scoreboard bench for gppcu_pipe_sequencer: a program-index model predicts the WB retire cycle of
// every instruction and the oDONE cycle; a negedge monitor pops and compares as the DUT presents them.
module tb_gppcu_pipe_sequencer;
    localparam int ABW = 11;
    localparam int DBW = 32;
    localparam int CWB = 16;

    logic           iACLK = 1'b0;
    logic           iRST, iSTART, iBUSY;
    logic [ABW-1:0] iSTART_PC;
    logic           oRUNNING, oDONE;
    logic [ABW-1:0] oIMEM_ADDR;
    logic [DBW-1:0] iIMEM_RDATA, oDEC_INSTR;
    logic [CWB-1:0] iDEC_CW;
    logic [DBW-1:0] oINSTR_FCH, oINSTR_DEC, oINSTR_EXEC, oINSTR_WB;
    logic [CWB-1:0] oCW_DEC, oCW_EXEC, oCW_WB;

    gppcu_pipe_sequencer dut (
        .iACLK(iACLK), .iRST(iRST), .iSTART(iSTART), .iSTART_PC(iSTART_PC),
        .oRUNNING(oRUNNING), .oDONE(oDONE), .oIMEM_ADDR(oIMEM_ADDR), .iIMEM_RDATA(iIMEM_RDATA),
        .oDEC_INSTR(oDEC_INSTR), .iDEC_CW(iDEC_CW), .iBUSY(iBUSY),
        .oINSTR_FCH(oINSTR_FCH), .oINSTR_DEC(oINSTR_DEC), .oINSTR_EXEC(oINSTR_EXEC),
        .oINSTR_WB(oINSTR_WB), .oCW_DEC(oCW_DEC), .oCW_EXEC(oCW_EXEC), .oCW_WB(oCW_WB)
    );

    always #5 iACLK = ~iACLK;

    // Decoder stand-in: opcodes below 0x20 write a register; bit 0 is always 1 (DUT must replace it).
    function automatic logic [CWB-1:0] decode(input logic [DBW-1:0] ins);
        logic [5:0] op;
        op = ins[31:26];
        return {op, ins[9:2], (op < 6'h20), 1'b1};
    endfunction
    assign iDEC_CW = decode(oDEC_INSTR);

    logic [DBW-1:0] mem [0:2047];
    always @(posedge iACLK) iIMEM_RDATA <= mem[oIMEM_ADDR];

    int cyc = 0;
    always @(posedge iACLK) cyc <= cyc + 1;

    typedef struct { logic [DBW-1:0] instr; int cyc; } wb_exp_t;
    wb_exp_t        wb_q[$];
    int             done_q[$];
    logic [DBW-1:0] prog[$];
    bit             busy_plan [0:299];
    int             checks = 0, passes = 0, done_seen = 0;

    localparam logic [DBW-1:0] HALT = {6'h3F, 26'd0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [DBW-1:0] mk(input int op, input int rd, input int ra, input int rb);
        logic [DBW-1:0] r;
        r = $urandom;
        r[31:26] = op[5:0];
        r[25:21] = rd[4:0];
        r[20:16] = ra[4:0];
        r[15:11] = rb[4:0];
        return r;
    endfunction

    // Instruction di reads a register written by instruction xi.
    function automatic bit dep(input int di, input int xi);
        logic [DBW-1:0] a, b;
        if (di < 0 || xi < 0) return 1'b0;
        a = prog[di];
        b = prog[xi];
        return (b[31:26] < 6'h20) && ((a[20:16] == b[25:21]) || (a[15:11] == b[25:21]));
    endfunction

    // Tracks which program index occupies each stage (-1 = empty) and applies the stall rules.
    task automatic model_kernel(input int t);
        int f, d, e, w, nf, nd, ne, nw;
        bit b, haz, hlt, halted;
        logic [DBW-1:0] di;
        f = 0; d = -1; e = -1; w = -1; halted = 1'b0;
        for (int rel = 2; rel < 250; rel++) begin
            b   = busy_plan[rel] && (e >= 0);
            haz = !b && (d >= 0) && (dep(d, e) || dep(d, w));
            hlt = 1'b0;
            if (!b && !haz && !halted && d >= 0) begin
                di  = prog[d];
                hlt = (di[31:26] == 6'h3F);
            end
            if (w >= 0) wb_q.push_back('{instr: prog[w], cyc: t + rel});
            if (b) begin
                nw = -1; ne = e; nd = d; nf = f;
            end else if (haz) begin
                nw = e; ne = -1; nd = d; nf = f;
            end else if (hlt) begin
                nw = e; ne = -1; nd = -1; nf = -1;
            end else begin
                nw = e; ne = d; nd = f; nf = (f >= 0) ? f + 1 : -1;
            end
            if (halted && ne < 0 && nw < 0) begin
                done_q.push_back(t + rel + 1);
                break;
            end
            if (hlt) halted = 1'b1;
            f = nf; d = nd; e = ne; w = nw;
        end
    endtask

    // Monitor: every valid WB and every oDONE pulse must match the head of its queue.
    always @(negedge iACLK) begin : monitor
        wb_exp_t ex;
        int      dc;
        if (!iRST) begin
            if (oCW_WB[0]) begin
                if (wb_q.size() == 0) check("wb_unexpected", oCW_WB[0], 1'b0);
                else begin
                    ex = wb_q.pop_front();
                    check("wb_instr", oINSTR_WB, ex.instr);
                    check("wb_cycle", cyc, ex.cyc);
                    check("wb_cw", oCW_WB, decode(ex.instr));
                end
            end
            if (oDONE) begin
                done_seen++;
                if (done_q.size() == 0) check("done_unexpected", oDONE, 1'b0);
                else begin
                    dc = done_q.pop_front();
                    check("done_cycle", cyc, dc);
                    check("running_at_done", oRUNNING, 1'b1);
                end
            end
        end
    end

    task automatic clear_plan();
        for (int i = 0; i < 300; i++) busy_plan[i] = 1'b0;
    endtask

    task automatic run_kernel(input logic [ABW-1:0] spc, input int rst_at);
        int t, d0;
        bit fin;
        logic [ABW-1:0] a;
        for (int k = 0; k < prog.size(); k++) begin
            a = spc + ABW'(k);
            mem[a] = prog[k];
        end
        @(posedge iACLK); #1;
        t  = cyc;
        d0 = done_seen;
        check("idle_not_running", oRUNNING, 1'b0);
        model_kernel(t);
        iSTART = 1'b1; iSTART_PC = spc; iBUSY = busy_plan[0];
        fin = 1'b0;
        for (int rel = 1; rel < 300 && !fin; rel++) begin
            @(posedge iACLK); #1;
            iSTART    = (rel <= 3);
            iSTART_PC = ABW'($urandom);
            iBUSY     = busy_plan[rel];
            if (rel == 1) begin
                check("running_fill", oRUNNING, 1'b1);
                check("imem_addr_fill", oIMEM_ADDR, spc);
            end
            if (rst_at > 0) begin
                if (rel == rst_at) iRST = 1'b1;
                else if (rel == rst_at + 1) begin
                    iRST = 1'b0; iBUSY = 1'b0;
                    wb_q.delete(); done_q.delete();
                    check("rst_dec_valid", oCW_DEC[0], 1'b0);
                    check("rst_exec_valid", oCW_EXEC[0], 1'b0);
                    check("rst_wb_valid", oCW_WB[0], 1'b0);
                    check("rst_running", oRUNNING, 1'b0);
                    check("rst_done", oDONE, 1'b0);
                end else if (rel == rst_at + 6) fin = 1'b1;
            end else if (done_seen != d0) fin = 1'b1;
        end
        iSTART = 1'b0; iBUSY = 1'b0;
        check("kernel_finished", fin, 1'b1);
        if (rst_at > 0) check("no_done_after_reset", done_seen - d0, 0);
        else            check("done_once", done_seen - d0, 1);
        check("scoreboard_drained", wb_q.size(), 0);
        repeat (2) @(posedge iACLK);
    endtask

    initial begin
        int n;
        iRST = 1'b1; iSTART = 1'b0; iSTART_PC = '0; iBUSY = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = mk($urandom_range(0, 62), $urandom, $urandom, $urandom);
        repeat (3) @(posedge iACLK); #1;
        check("reset_running", oRUNNING, 1'b0);
        check("reset_done", oDONE, 1'b0);
        check("reset_imem_addr", oIMEM_ADDR, 11'h000);
        check("reset_instr_dec", oINSTR_DEC, 32'h0);
        check("reset_instr_exec", oINSTR_EXEC, 32'h0);
        check("reset_instr_wb", oINSTR_WB, 32'h0);
        check("reset_cw_dec_valid", oCW_DEC[0], 1'b0);
        check("reset_cw_exec", oCW_EXEC, 16'h0);
        check("reset_cw_wb", oCW_WB, 16'h0);
        iRST = 1'b0;

        // Three independent ALU ops then HALT.
        prog.delete(); clear_plan();
        prog.push_back(mk(1, 1, 5, 6)); prog.push_back(mk(2, 2, 5, 6));
        prog.push_back(mk(3, 3, 5, 6)); prog.push_back(HALT);
        run_kernel(11'h010, -1);

        // Back-to-back RAW dependency on r3.
        prog.delete(); clear_plan();
        prog.push_back(mk(1, 3, 1, 2)); prog.push_back(mk(1, 4, 3, 5)); prog.push_back(HALT);
        run_kernel(11'h040, -1);

        // FPU op held in EXEC by five busy cycles.
        prog.delete(); clear_plan();
        prog.push_back(mk(6'h10, 7, 1, 2)); prog.push_back(mk(1, 8, 9, 10)); prog.push_back(HALT);
        for (int r = 4; r <= 8; r++) busy_plan[r] = 1'b1;
        run_kernel(11'h080, -1);

        // Busy coincident with a hazard.
        prog.delete(); clear_plan();
        prog.push_back(mk(6'h10, 3, 1, 2)); prog.push_back(mk(1, 4, 3, 6)); prog.push_back(HALT);
        busy_plan[4] = 1'b1; busy_plan[5] = 1'b1;
        run_kernel(11'h0C0, -1);

        // PC wrap from the top of IMEM.
        prog.delete(); clear_plan();
        prog.push_back(mk(1, 1, 5, 6)); prog.push_back(mk(2, 2, 5, 6)); prog.push_back(HALT);
        run_kernel(11'h7FF, -1);

        // Reset mid-run while busy, then a clean restart.
        prog.delete(); clear_plan();
        for (int k = 0; k < 8; k++) prog.push_back(mk(1, k + 8, 20, 21));
        prog.push_back(HALT);
        for (int r = 5; r <= 30; r++) busy_plan[r] = 1'b1;
        run_kernel(11'h200, 7);
        prog.delete(); clear_plan();
        prog.push_back(mk(1, 1, 5, 6)); prog.push_back(mk(2, 2, 1, 6)); prog.push_back(HALT);
        run_kernel(11'h100, -1);

        // Random kernels with dense register reuse and random busy.
        for (int k = 0; k < 20; k++) begin
            prog.delete(); clear_plan();
            n = $urandom_range(1, 10);
            for (int j = 0; j < n; j++)
                prog.push_back(mk($urandom_range(0, 62), $urandom_range(0, 7),
                                  $urandom_range(0, 7), $urandom_range(0, 7)));
            prog.push_back(HALT);
            for (int r = 2; r <= 60; r++) busy_plan[r] = ($urandom_range(0, 3) == 0);
            run_kernel(ABW'($urandom), -1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
